// File: rtl/conv_encoder_2_1_4_if.sv
// Frame-request / encoded-frame bundle between a message source and the
// rate-1/2 K=4 convolutional encoder. The encoder side uses the slave modport.
interface conv_encoder_2_1_4_if;
  logic        start;
  logic [3:0]  msg;
  logic        busy;
  logic [13:0] code_out;
  logic        code_valid;

  modport master (
    output start,
    output msg,
    input  busy,
    input  code_out,
    input  code_valid
  );

  modport slave (
    input  start,
    input  msg,
    output busy,
    output code_out,
    output code_valid
  );
endinterface

// File: rtl/conv_encoder_2_1_4.sv
// Rate-1/2, K=4 feed-forward convolutional encoder. Each accepted request
// encodes msg[3..0] followed by three zero tail bits (7 steps), shifting the
// parity pairs into a frame buffer. code_out is loaded only once the whole
// 14-bit frame is complete, so the downstream decoder never sees a partial
// frame.
module conv_encoder_2_1_4 #(
  parameter logic [3:0] G1 = 4'b1111,  // taps {current, d1, d2, d3}
  parameter logic [3:0] G2 = 4'b1101   // taps {current, d1, d2, d3}
) (
  input  logic                 clk,
  input  logic                 reset,  // synchronous, active-low
  conv_encoder_2_1_4_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ENC  = 1'b1
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'd6;

  // XOR reduction of the generator-tapped bits
  function automatic logic tap_parity(input logic [3:0] taps, input logic [3:0] bits);
    return ^(taps & bits);
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;      // step index 0..6
  logic [2:0]  enc_q, enc_d;      // {d1, d2, d3}, d1 = most recent past input
  logic [3:0]  msg_q, msg_d;
  logic [11:0] frame_q, frame_d;  // pairs from steps 0..5, oldest in the MSBs
  logic [13:0] code_q, code_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic        u_s;
  logic        p1_s;
  logic        p2_s;
  logic [13:0] frame_full_s;

  // Current input bit: message bits MSB-first for steps 0..3, zero tail after
  always_comb begin
    case (cnt_q)
      3'd0:    u_s = msg_q[3];
      3'd1:    u_s = msg_q[2];
      3'd2:    u_s = msg_q[1];
      3'd3:    u_s = msg_q[0];
      default: u_s = 1'b0;
    endcase
  end

  // Parity pair for the current step and the frame it would complete
  always_comb begin
    p1_s         = tap_parity(G1, {u_s, enc_q});
    p2_s         = tap_parity(G2, {u_s, enc_q});
    frame_full_s = {frame_q, p1_s, p2_s};
  end

  // Next-state and output logic of the IDLE/ENC controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    msg_d   = msg_q;
    frame_d = frame_q;
    code_d  = code_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ENC;
          msg_d   = bus.msg;
          enc_d   = 3'b000;
          cnt_d   = 3'd0;
          frame_d = 12'h000;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENC: begin
        enc_d   = {u_s, enc_q[2:1]};
        frame_d = frame_full_s[11:0];
        if (cnt_q == LAST_STEP) begin
          // Last step: publish the complete frame in one go
          code_d  = frame_full_s;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      enc_q   <= 3'b000;
      msg_q   <= 4'h0;
      frame_q <= 12'h000;
      code_q  <= 14'h0000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      msg_q   <= msg_d;
      frame_q <= frame_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;

endmodule

// File: tb/tb_conv_encoder_2_1_4.sv
// Directed, table-driven bench for conv_encoder_2_1_4. Expected frames are
// hand-computed codewords for every 4-bit message.
module tb_conv_encoder_2_1_4;

  logic clk;
  logic reset;

  conv_encoder_2_1_4_if bus ();

  conv_encoder_2_1_4 #(
    .G1(4'b1111),
    .G2(4'b1101)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [3:0]  msg;
    logic [13:0] code;
  } vec_t;

  vec_t        vecs[16];
  int          errors;
  int          checks;
  logic [13:0] prev_code;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One frame with a 1-clock start; msg is scrambled during ENC.
  task automatic run_frame(input logic [3:0] m, input logic [13:0] exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.msg   = m;
    @(negedge clk);            // E0 has passed
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("busy_during_frame", {31'd0, bus.busy}, 32'd1);
      check("valid_low_during_frame", {31'd0, bus.code_valid}, 32'd0);
      check("code_held_during_frame", {18'd0, bus.code_out}, {18'd0, prev_code});
      bus.msg   = ~m ^ 4'(i);
      bus.start = (i == 3) ? 1'b1 : 1'b0;  // ignored while busy
      @(negedge clk);          // after E1..E7
    end
    bus.start = 1'b0;
    check("busy_low_after_frame", {31'd0, bus.busy}, 32'd0);
    check("valid_after_frame", {31'd0, bus.code_valid}, 32'd1);
    check("code_out", {18'd0, bus.code_out}, {18'd0, exp});
    prev_code = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    prev_code = 14'h0000;

    vecs[0]  = '{4'h0, 14'h0000};
    vecs[1]  = '{4'h1, 14'h00FB};
    vecs[2]  = '{4'h2, 14'h03EC};
    vecs[3]  = '{4'h3, 14'h0317};
    vecs[4]  = '{4'h4, 14'h0FB0};
    vecs[5]  = '{4'h5, 14'h0F4B};
    vecs[6]  = '{4'h6, 14'h0C5C};
    vecs[7]  = '{4'h7, 14'h0CA7};
    vecs[8]  = '{4'h8, 14'h3EC0};
    vecs[9]  = '{4'h9, 14'h3E3B};
    vecs[10] = '{4'hA, 14'h3D2C};
    vecs[11] = '{4'hB, 14'h3DD7};
    vecs[12] = '{4'hC, 14'h3170};
    vecs[13] = '{4'hD, 14'h318B};
    vecs[14] = '{4'hE, 14'h329C};
    vecs[15] = '{4'hF, 14'h3267};

    // Reset low for 2 clocks
    bus.start = 1'b0;
    bus.msg   = 4'h0;
    reset     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_valid", {31'd0, bus.code_valid}, 32'd0);
    check("reset_code", {18'd0, bus.code_out}, 32'd0);

    // Named directed frames
    run_frame(4'b1011, 14'h3DD7);
    run_frame(4'b1000, 14'h3EC0);
    run_frame(4'b1111, 14'h3267);
    run_frame(4'b0000, 14'h0000);

    // Every message value, back to back
    for (int v = 0; v < 16; v++) begin
      run_frame(vecs[v].msg, vecs[v].code);
    end

    // Valid stays up while idle
    repeat (3) @(negedge clk);
    check("valid_holds_idle", {31'd0, bus.code_valid}, 32'd1);
    check("code_holds_idle", {18'd0, bus.code_out}, {18'd0, prev_code});

    // start held high for 24 clocks: accepts at E0, E8, E16
    @(negedge clk);
    bus.start = 1'b1;
    bus.msg   = 4'b1011;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);          // after edge E_c
      if ((c % 8) == 7) begin
        check("stream_busy_low", {31'd0, bus.busy}, 32'd0);
        check("stream_valid_high", {31'd0, bus.code_valid}, 32'd1);
        check("stream_code", {18'd0, bus.code_out}, 32'h3DD7);
        bus.msg = 4'b1011;
      end else begin
        check("stream_busy_high", {31'd0, bus.busy}, 32'd1);
        check("stream_valid_low", {31'd0, bus.code_valid}, 32'd0);
        bus.msg = 4'(c * 5 + 2);
      end
    end
    bus.start = 1'b0;
    prev_code = 14'h3DD7;

    // Reset on the step-3 edge aborts the frame
    @(negedge clk);
    bus.start = 1'b1;
    bus.msg   = 4'b0110;
    @(negedge clk);            // after E0
    bus.start = 1'b0;
    @(negedge clk);            // after E1 (step 0)
    @(negedge clk);            // after E2 (step 1)
    @(negedge clk);            // after E3 (step 2)
    reset = 1'b0;
    @(negedge clk);            // after E4, step 3 replaced by reset
    reset = 1'b1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_valid", {31'd0, bus.code_valid}, 32'd0);
    check("abort_code", {18'd0, bus.code_out}, 32'd0);
    repeat (6) @(negedge clk);
    check("abort_no_valid_later", {31'd0, bus.code_valid}, 32'd0);
    check("abort_code_later", {18'd0, bus.code_out}, 32'd0);
    prev_code = 14'h0000;
    run_frame(4'b1000, 14'h3EC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder_2_1_4.md
CONV_ENCODER_2_1_4 -- requirements
Module: conv_encoder_2_1_4

Interface
REQ-001 The block SHALL have these parameters:
- G1, 4'b1111, first generator taps {current, d1, d2, d3}.
- G2, 4'b1101, second generator taps {current, d1, d2, d3}.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request to encode msg; sampled only in IDLE.
- msg  in  4  information bits, msg[3] encoded first.
- busy  out  1  high while a frame is being encoded.
- code_out  out  14  encoded frame; feeds the Viterbi decoder's 14-bit data input.
- code_valid  out  1  level; code_out holds a complete frame; feeds the decoder's ready.

Function
REQ-003 The block SHALL implement a rate-1/2, K=4 feed-forward convolutional encoder with a 3-bit state {d1,d2,d3}, where d1 is the most recent past input.
REQ-004 Each frame SHALL encode 7 input bits u0..u6: u0..u3 = msg[3], msg[2], msg[1], msg[0], then u4..u6 = 0 (tail flush).
REQ-005 The encoder state SHALL be cleared to 000 when a frame is accepted, so every frame starts from state 0.
REQ-006 At step k, the outputs SHALL be computed as follows:
- p1 = XOR of G1-tapped bits of {u_k, d1, d2, d3}.
- p2 = the same for G2.
- Then d3<=d2, d2<=d1, d1<=u_k.
REQ-007 Step k SHALL write p1 to frame bit [13-2k] and p2 to frame bit [12-2k], with k=0..6.
REQ-008 The block SHALL have exactly two FSM states, IDLE and ENC, with a 3-bit step counter (0..6).
REQ-009 In IDLE with start=1 at a rising edge (E0), the block SHALL:
- latch msg;
- clear the encoder state, the counter and the internal frame buffer;
- set busy=1 and code_valid=0;
- go to ENC.
REQ-010 In ENC, the block SHALL perform one step per clock at edges E1..E7 (steps 0..6).
REQ-011 On the step-6 edge (E7), the block SHALL load the full frame into code_out, set code_valid=1, set busy=0 and return to IDLE.
REQ-012 Latency from the start-accept edge to code_valid=1 SHALL be 7 clocks; the minimum frame period SHALL be 8 clocks.
REQ-013 code_out SHALL change only on the E7 edge or on reset, so the downstream decoder never sees a partial frame.
REQ-014 start SHALL be ignored while busy=1, and msg changes after E0 SHALL NOT affect the current frame.
REQ-015 code_valid SHALL stay 1 until the next accepted start, and code_out SHALL keep the previous frame until that next frame completes.
REQ-016 With start held high continuously, frames SHALL be accepted at E0, E8, E16, ...
REQ-017 The step counter SHALL NOT wrap inside a frame; it SHALL be reset to 0 on acceptance.

Reset
REQ-018 When reset=0 at a rising edge, the block SHALL set:
- state to IDLE;
- encoder state, counter, latched msg and frame buffer to 0;
- busy=0, code_valid=0, code_out=14'h0000.
REQ-019 Reset SHALL take priority over start and over any in-progress step.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no code_valid pulse; after reset=1, the block SHALL accept a new start normally.
REQ-021 Outputs SHALL be undefined-free (no X) from the first reset edge onward.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset low 2 clocks, then high -> busy=0, code_valid=0, code_out=14'h0000.
- msg=4'b1011 with a 1-clock start -> busy=1 for 7 clocks, then code_valid=1 and code_out=14'h3DD7 (pairs 11 11 01 11 01 01 11).
- msg=4'b1000 -> code_out=14'h3EC0; then msg=4'b1111 -> code_out=14'h3267; then msg=4'b0000 -> code_out=14'h0000.
- start held high for 24 clocks with msg=4'b1011 -> frames accepted at E0, E8, E16; code_valid falls at each accept and rises 7 clocks later; msg toggled during ENC has no effect.
- Reset pulsed at step 3 of a frame -> no code_valid, code_out=0; next start with msg=4'b1000 -> 14'h3EC0 after 7 clocks.
- Loopback: connect code_out/code_valid to the decoder and apply all 16 msg values -> decoder output equals {msg,3'b000} for each frame.
